// File: rtl/xgmii_baser_dec_64_pkg.sv
// Shared constants for the 64b/66b receive decoder: sync headers, block types,
// XGMII characters, 7-bit control codes and the block-class tag used by the framing FSM.
package xgmii_baser_dec_64_pkg;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    localparam logic [7:0] BT_CTRL   = 8'h1E;
    localparam logic [7:0] BT_START0 = 8'h78;
    localparam logic [7:0] BT_START4 = 8'h33;
    localparam logic [7:0] BT_OS     = 8'h4B;
    localparam logic [7:0] BT_TERM0  = 8'h87;
    localparam logic [7:0] BT_TERM1  = 8'h99;
    localparam logic [7:0] BT_TERM2  = 8'hAA;
    localparam logic [7:0] BT_TERM3  = 8'hB4;
    localparam logic [7:0] BT_TERM4  = 8'hCC;
    localparam logic [7:0] BT_TERM5  = 8'hD2;
    localparam logic [7:0] BT_TERM6  = 8'hE1;
    localparam logic [7:0] BT_TERM7  = 8'hFF;

    localparam logic [7:0] CH_I = 8'h07;
    localparam logic [7:0] CH_S = 8'hFB;
    localparam logic [7:0] CH_T = 8'hFD;
    localparam logic [7:0] CH_E = 8'hFE;
    localparam logic [7:0] CH_O = 8'h9C;

    localparam logic [6:0] CC_IDLE  = 7'h00;
    localparam logic [6:0] CC_ERROR = 7'h1E;

    localparam logic [63:0] BLK_IDLE = 64'h0707070707070707;
    localparam logic [63:0] BLK_ERR  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] BLK_LF   = 64'h0100009C0100009C;
    localparam logic [7:0]  RXC_LF   = 8'h11;

    typedef enum logic [2:0] {
        K_DATA,
        K_START,
        K_TERM,
        K_CTRL,
        K_BAD
    } blk_kind_e;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_FRAME
    } frame_state_e;

    // Lane index of /T/ for a terminate block type; 8 means "not a terminate".
    function automatic logic [3:0] term_lane(input logic [7:0] t);
        case (t)
            BT_TERM0: return 4'd0;
            BT_TERM1: return 4'd1;
            BT_TERM2: return 4'd2;
            BT_TERM3: return 4'd3;
            BT_TERM4: return 4'd4;
            BT_TERM5: return 4'd5;
            BT_TERM6: return 4'd6;
            BT_TERM7: return 4'd7;
            default:  return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/baser_ctrl_code_dec.sv
// Maps one 7-bit 64b/66b control code to its XGMII character; unknown codes become /E/.
module baser_ctrl_code_dec
    import xgmii_baser_dec_64_pkg::*;
(
    input  logic [6:0] i_code,
    output logic [7:0] o_char,
    output logic       o_invalid
);

    always_comb begin
        o_char    = CH_E;
        o_invalid = 1'b1;
        case (i_code)
            CC_IDLE: begin
                o_char    = CH_I;
                o_invalid = 1'b0;
            end
            CC_ERROR: begin
                o_char    = CH_E;
                o_invalid = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/xgmii_baser_dec_64.sv
// 64b/66b receive block decoder to XGMII with one-cycle latency, framing-order
// checking, and local-fault substitution while block lock is lost.
module xgmii_baser_dec_64
    import xgmii_baser_dec_64_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] encoded_rx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_rx_hdr,
    input  logic                  rx_block_lock,
    output logic [DATA_WIDTH-1:0] xgmii_rxd,
    output logic [CTRL_WIDTH-1:0] xgmii_rxc,
    output logic                  rx_bad_block,
    output logic                  rx_sequence_error
);
    // state    | meaning
    // ST_IDLE  | between frames; a data block here is out of order
    // ST_FRAME | start seen; data expected until a terminate

    if (DATA_WIDTH != 64 || CTRL_WIDTH != 8 || HDR_WIDTH != 2) begin : g_param_chk
        $error("xgmii_baser_dec_64 supports only DATA_WIDTH=64, CTRL_WIDTH=8, HDR_WIDTH=2");
    end

    logic [7:0]      w_type;
    logic [63:0]     w_tdata;
    logic [3:0]      w_k;
    logic [7:0][7:0] w_code_char;
    logic [7:0]      w_code_inv;
    logic [7:0][7:0] w_dec_rxd;
    logic [7:0]      w_dec_rxc;
    logic            w_dec_bad;
    blk_kind_e       w_kind;

    frame_state_e    r_state, w_state_nxt;
    logic [63:0]     w_rxd;
    logic [7:0]      w_rxc;
    logic            w_bad, w_seq;
    logic [63:0]     r_rxd;
    logic [7:0]      r_rxc;
    logic            r_bad, r_seq;

    assign w_type  = encoded_rx_data[7:0];
    assign w_tdata = {8'h00, encoded_rx_data[63:8]};
    assign w_k     = term_lane(w_type);

    // Codes of 0x1E, 0x33 and 0x4B blocks all sit at bit 8+7n, so one decoder per lane serves all three.
    for (genvar g = 0; g < 8; g++) begin : g_code
        baser_ctrl_code_dec u_code_dec (
            .i_code    (encoded_rx_data[8+7*g +: 7]),
            .o_char    (w_code_char[g]),
            .o_invalid (w_code_inv[g])
        );
    end

    always_comb begin
        w_dec_rxd = BLK_ERR;
        w_dec_rxc = 8'hFF;
        w_dec_bad = 1'b0;
        w_kind    = K_CTRL;
        if (encoded_rx_hdr == HDR_DATA) begin
            w_dec_rxd = encoded_rx_data;
            w_dec_rxc = 8'h00;
            w_kind    = K_DATA;
        end else if (encoded_rx_hdr == HDR_CTRL) begin
            case (w_type)
                BT_CTRL: begin
                    w_dec_rxd = w_code_char;
                    w_dec_bad = |w_code_inv;
                end
                BT_START0: begin
                    w_dec_rxd = {encoded_rx_data[63:8], CH_S};
                    w_dec_rxc = 8'h01;
                    w_kind    = K_START;
                end
                BT_START4: begin
                    w_dec_rxd = {encoded_rx_data[63:40], CH_S, w_code_char[3:0]};
                    w_dec_rxc = 8'h1F;
                    w_dec_bad = |w_code_inv[3:0];
                    w_kind    = K_START;
                end
                BT_OS: begin
                    if (encoded_rx_data[35:32] == 4'h0) begin
                        w_dec_rxd = {w_code_char[7:4], encoded_rx_data[31:8], CH_O};
                        w_dec_rxc = 8'hF1;
                        w_dec_bad = |w_code_inv[7:4];
                    end else begin
                        w_dec_bad = 1'b1;
                    end
                end
                default: begin
                    if (!w_k[3]) begin
                        w_kind = K_TERM;
                        for (int i = 0; i < 8; i++) begin
                            if (4'(i) < w_k) begin
                                w_dec_rxd[i] = w_tdata[8*i +: 8];
                                w_dec_rxc[i] = 1'b0;
                            end else if (4'(i) == w_k) begin
                                w_dec_rxd[i] = CH_T;
                            end else begin
                                w_dec_rxd[i] = CH_I;
                            end
                        end
                    end else begin
                        w_dec_bad = 1'b1;
                    end
                end
            endcase
        end else begin
            w_dec_bad = 1'b1;
        end
        if (w_dec_bad) w_kind = K_BAD;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rxd       = w_dec_rxd;
        w_rxc       = w_dec_rxc;
        w_bad       = w_dec_bad;
        w_seq       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_kind == K_DATA) begin
                    w_rxd = BLK_ERR;
                    w_rxc = 8'hFF;
                    w_seq = 1'b1;
                end else if (w_kind == K_START) begin
                    w_state_nxt = ST_FRAME;
                end
            end
            ST_FRAME: begin
                case (w_kind)
                    K_DATA: ;
                    K_TERM: w_state_nxt = ST_IDLE;
                    K_START: begin
                        w_rxd = BLK_ERR;
                        w_rxc = 8'hFF;
                        w_seq = 1'b1;
                    end
                    default: begin
                        w_rxd       = BLK_ERR;
                        w_rxc       = 8'hFF;
                        w_seq       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!rx_block_lock) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd <= BLK_IDLE;
            r_rxc <= 8'hFF;
            r_bad <= 1'b0;
            r_seq <= 1'b0;
        end else if (!rx_block_lock) begin
            r_rxd <= BLK_LF;
            r_rxc <= RXC_LF;
            r_bad <= 1'b0;
            r_seq <= 1'b0;
        end else begin
            r_rxd <= w_rxd;
            r_rxc <= w_rxc;
            r_bad <= w_bad;
            r_seq <= w_seq;
        end
    end

    assign xgmii_rxd         = r_rxd;
    assign xgmii_rxc         = r_rxc;
    assign rx_bad_block      = r_bad;
    assign rx_sequence_error = r_seq;

endmodule

// File: tb/tb_xgmii_baser_dec_64.sv
// Bench for xgmii_baser_dec_64: directed framing scenarios followed by random
// blocks, all compared against a byte-level reference decoder and frame flag.
module tb_xgmii_baser_dec_64;

    logic        clk = 1'b0;
    logic        rst;
    logic        lock;
    logic [1:0]  hdr;
    logic [63:0] din;
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic        bad, seq;

    int n_total = 0;
    int n_bad   = 0;
    bit m_frame = 1'b0;

    localparam int CLS_DATA  = 0;
    localparam int CLS_START = 1;
    localparam int CLS_TERM  = 2;
    localparam int CLS_CTRL  = 3;
    localparam int CLS_BAD   = 4;

    xgmii_baser_dec_64 dut (
        .clk               (clk),
        .rst               (rst),
        .encoded_rx_data   (din),
        .encoded_rx_hdr    (hdr),
        .rx_block_lock     (lock),
        .xgmii_rxd         (rxd),
        .xgmii_rxc         (rxc),
        .rx_bad_block      (bad),
        .rx_sequence_error (seq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_decode(input logic [1:0] h, input logic [63:0] d,
                                       output logic [63:0] o_d, output logic [7:0] o_c,
                                       output bit o_bad, output int cls);
        logic [7:0] lane [8];
        bit         ctl  [8];
        logic [7:0] terms [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        logic [7:0] t = d[7:0];
        logic [6:0] c;
        int         k = -1;
        o_bad = 1'b0;
        cls   = CLS_CTRL;
        for (int i = 0; i < 8; i++) begin
            lane[i] = 8'hFE;
            ctl[i]  = 1'b1;
        end
        if (h == 2'b01) begin
            cls = CLS_DATA;
            for (int i = 0; i < 8; i++) begin
                lane[i] = 8'(d >> (8 * i));
                ctl[i]  = 1'b0;
            end
        end else if (h != 2'b10) begin
            o_bad = 1'b1;
        end else begin
            for (int i = 0; i < 8; i++) if (t == terms[i]) k = i;
            if (t == 8'h1E) begin
                for (int i = 0; i < 8; i++) begin
                    c = 7'(d >> (8 + 7 * i));
                    lane[i] = (c == 7'h00) ? 8'h07 : 8'hFE;
                    if (c != 7'h00 && c != 7'h1E) o_bad = 1'b1;
                end
            end else if (t == 8'h78) begin
                cls = CLS_START;
                lane[0] = 8'hFB;
                for (int i = 1; i < 8; i++) begin
                    lane[i] = 8'(d >> (8 * i));
                    ctl[i]  = 1'b0;
                end
            end else if (t == 8'h33) begin
                cls = CLS_START;
                for (int i = 0; i < 4; i++) begin
                    c = 7'(d >> (8 + 7 * i));
                    lane[i] = (c == 7'h00) ? 8'h07 : 8'hFE;
                    if (c != 7'h00 && c != 7'h1E) o_bad = 1'b1;
                end
                lane[4] = 8'hFB;
                for (int i = 5; i < 8; i++) begin
                    lane[i] = 8'(d >> (8 * i));
                    ctl[i]  = 1'b0;
                end
            end else if (t == 8'h4B && d[35:32] == 4'h0) begin
                lane[0] = 8'h9C;
                for (int i = 1; i < 4; i++) begin
                    lane[i] = 8'(d >> (8 * i));
                    ctl[i]  = 1'b0;
                end
                for (int i = 4; i < 8; i++) begin
                    c = 7'(d >> (36 + 7 * (i - 4)));
                    lane[i] = (c == 7'h00) ? 8'h07 : 8'hFE;
                    if (c != 7'h00 && c != 7'h1E) o_bad = 1'b1;
                end
            end else if (k >= 0) begin
                cls = CLS_TERM;
                for (int i = 0; i < 8; i++) begin
                    if (i < k) begin
                        lane[i] = 8'(d >> (8 + 8 * i));
                        ctl[i]  = 1'b0;
                    end else if (i == k) begin
                        lane[i] = 8'hFD;
                    end else begin
                        lane[i] = 8'h07;
                    end
                end
            end else begin
                o_bad = 1'b1;
            end
        end
        if (o_bad) cls = CLS_BAD;
        o_d = '0;
        o_c = '0;
        for (int i = 0; i < 8; i++) begin
            o_d = o_d | (64'(lane[i]) << (8 * i));
            o_c[i] = ctl[i];
        end
    endfunction

    task automatic ref_cycle(input bit r, input bit l, input logic [1:0] h, input logic [63:0] d,
                             output logic [63:0] e_d, output logic [7:0] e_c,
                             output bit e_b, output bit e_s);
        int  cls;
        bit  err_blk = 1'b0;
        e_s = 1'b0;
        if (r) begin
            e_d = 64'h0707070707070707; e_c = 8'hFF; e_b = 1'b0; m_frame = 1'b0;
            return;
        end
        if (!l) begin
            e_d = 64'h0100009C0100009C; e_c = 8'h11; e_b = 1'b0; m_frame = 1'b0;
            return;
        end
        ref_decode(h, d, e_d, e_c, e_b, cls);
        if (!m_frame) begin
            if (cls == CLS_DATA) begin err_blk = 1'b1; e_s = 1'b1; end
            else if (cls == CLS_START) m_frame = 1'b1;
        end else begin
            if (cls == CLS_TERM) m_frame = 1'b0;
            else if (cls == CLS_START) begin err_blk = 1'b1; e_s = 1'b1; end
            else if (cls != CLS_DATA) begin err_blk = 1'b1; e_s = 1'b1; m_frame = 1'b0; end
        end
        if (err_blk) begin
            e_d = 64'hFEFEFEFEFEFEFEFE;
            e_c = 8'hFF;
        end
    endtask

    task automatic step(input bit r, input bit l, input logic [1:0] h, input logic [63:0] d);
        logic [63:0] e_d;
        logic [7:0]  e_c;
        bit          e_b, e_s;
        rst = r; lock = l; hdr = h; din = d;
        ref_cycle(r, l, h, d, e_d, e_c, e_b, e_s);
        @(posedge clk);
        #1;
        check_val("rxd", rxd, e_d);
        check_val("rxc", 64'(rxc), 64'(e_c));
        check_val("bad_block", 64'(bad), 64'(e_b));
        check_val("seq_error", 64'(seq), 64'(e_s));
    endtask

    function automatic logic [63:0] rnd_ctrl_block();
        logic [7:0]  types [13] = '{8'h1E, 8'h78, 8'h33, 8'h4B, 8'h87, 8'h99, 8'hAA,
                                    8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF, 8'h00};
        logic [63:0] d = {$urandom, $urandom};
        logic [6:0]  c;
        int          sel = $urandom_range(0, 12);
        d[7:0] = (sel == 12) ? 8'($urandom) : types[sel];
        if (d[7:0] == 8'h1E || d[7:0] == 8'h33 || d[7:0] == 8'h4B) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 19) == 0) c = 7'($urandom);
                else c = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h1E;
                if (d[7:0] == 8'h1E || (d[7:0] == 8'h33 && i < 4))
                    d[8+7*i +: 7] = c;
                else if (d[7:0] == 8'h4B && i >= 4)
                    d[36+7*(i-4) +: 7] = c;
            end
            if (d[7:0] == 8'h4B && $urandom_range(0, 4) != 0) d[35:32] = 4'h0;
        end
        return d;
    endfunction

    initial begin
        logic [1:0] h;
        bit         l;
        rst = 1'b1; lock = 1'b0; hdr = 2'b00; din = '0;

        step(1'b1, 1'b0, 2'b00, 64'h0);
        step(1'b1, 1'b1, 2'b00, 64'h0);
        check_val("reset_rxd", rxd, 64'h0707070707070707);
        check_val("reset_rxc", 64'(rxc), 64'hFF);

        step(1'b0, 1'b1, 2'b10, 64'h000000000000001E);
        check_val("idle_rxd", rxd, 64'h0707070707070707);
        check_val("idle_flags", 64'({bad, seq}), 64'h0);

        step(1'b0, 1'b1, 2'b10, 64'hD555555555555578);
        check_val("start_rxd", rxd, 64'hD5555555555555FB);
        check_val("start_rxc", 64'(rxc), 64'h01);
        step(1'b0, 1'b1, 2'b01, 64'h1122334455667788);
        check_val("data_rxd", rxd, 64'h1122334455667788);
        step(1'b0, 1'b1, 2'b10, 64'h07060504030201FF);
        check_val("term7_rxd", rxd, 64'hFD07060504030201);
        check_val("term7_rxc", 64'(rxc), 64'h80);

        step(1'b0, 1'b1, 2'b10, 64'hD555555555555578);
        step(1'b0, 1'b1, 2'b11, 64'h0123456789ABCDEF);
        check_val("hdr11_flags", 64'({bad, seq}), 64'h3);
        step(1'b0, 1'b1, 2'b01, 64'h0123456789ABCDEF);
        check_val("after_bad_rxd", rxd, 64'hFEFEFEFEFEFEFEFE);
        check_val("after_bad_seq", 64'(seq), 64'h1);

        step(1'b0, 1'b1, 2'b10, 64'hD555555555555578);
        check_val("restart_seq", 64'(seq), 64'h0);
        step(1'b0, 1'b1, 2'b01, 64'hCAFEF00DDEADBEEF);
        step(1'b0, 1'b0, 2'b01, 64'hCAFEF00DDEADBEEF);
        check_val("lf_rxd", rxd, 64'h0100009C0100009C);
        check_val("lf_rxc", 64'(rxc), 64'h11);
        step(1'b0, 1'b1, 2'b01, 64'h1111111111111111);
        check_val("relock_seq", 64'(seq), 64'h1);

        step(1'b0, 1'b1, 2'b10, 64'hD555550000000033);
        check_val("start4_rxd", rxd, 64'hD55555FB07070707);
        check_val("start4_rxc", 64'(rxc), 64'h1F);
        step(1'b1, 1'b1, 2'b01, 64'h2222222222222222);
        step(1'b0, 1'b1, 2'b10, 64'hD555555555555578);
        check_val("post_rst_start_seq", 64'(seq), 64'h0);
        step(1'b0, 1'b1, 2'b10, 64'h00000000000000AA);

        for (int n = 0; n < 2000; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 55)      h = 2'b01;
            else if (r < 95) h = 2'b10;
            else             h = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            l = ($urandom_range(0, 39) != 0);
            step($urandom_range(0, 199) == 0, l, h,
                 (h == 2'b10) ? rnd_ctrl_block() : {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/xgmii_baser_dec_64.md
XGMII_BASER_DEC_64 -- requirements
Module: xgmii_baser_dec_64

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the width of the encoded block payload and XGMII data; only 64 is legal, any other value fails elaboration.
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8, SHALL set the XGMII control width; only 8 is legal.
REQ-003 Parameter HDR_WIDTH, default 2, SHALL set the sync header width; only 2 is legal.
REQ-004 clk  input  1  SHALL be the single clock; all logic rises on its posedge.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 encoded_rx_data  input  64  SHALL carry the descrambled 64b/66b block payload, bit 0 first on the wire.
REQ-007 encoded_rx_hdr  input  2  SHALL carry the sync header: 2'b01 data, 2'b10 control.
REQ-008 rx_block_lock  input  1  SHALL indicate frame-sync lock from the RX interface.
REQ-009 xgmii_rxd  output  64  SHALL carry the XGMII data, lane 0 in bits 7:0.
REQ-010 xgmii_rxc  output  8  SHALL carry XGMII control, bit n for lane n.
REQ-011 rx_bad_block  output  1  SHALL pulse for one cycle per undecodable block.
REQ-012 rx_sequence_error  output  1  SHALL pulse for one cycle per framing-order violation.

Function
REQ-013 Latency SHALL be exactly one cycle: a block at the input on cycle N appears decoded on all outputs after edge N+1; one block per cycle, no stall.
REQ-014 Header 01 SHALL give rxd = encoded_rx_data and rxc = 0x00.
REQ-015 Header 00 or 11 SHALL give an error block (rxd = 0xFEFEFEFEFEFEFEFE, rxc = 0xFF) and assert rx_bad_block.
REQ-016 For header 10, the block type SHALL be encoded_rx_data[7:0].
REQ-017 Type 0x1E SHALL decode eight 7-bit codes at bits 8+7n: 0x00 to /I/ 0x07, 0x1E to /E/ 0xFE, and any other code to 0xFE plus rx_bad_block; rxc = 0xFF.
REQ-018 Type 0x78 SHALL give lane 0 = /S/ 0xFB with rxc[0]=1, and lanes 1-7 = data bits 63:8 with rxc[7:1]=0.
REQ-019 Type 0x33 SHALL give lanes 0-3 from 7-bit codes at bits 8+7n (n=0..3), lane 4 = 0xFB, and lanes 5-7 = data bits 63:40; rxc = 0x1F.
REQ-020 Type 0x4B with bits 35:32 = 0 SHALL give lane 0 = 0x9C, lanes 1-3 = bits 31:8, and lanes 4-7 from codes at bits 36+7n; rxc = 0xF1.
REQ-021 Terminate types 0x87,0x99,0xAA,0xB4,0xCC,0xD2,0xE1,0xFF SHALL map to k = 0..7:
- lanes 0..k-1 = data bytes from bits 8 upward, rxc = 0;
- lane k = /T/ 0xFD;
- lanes k+1..7 = 0x07;
- rxc = 1 for lanes k..7.
REQ-022 Any other control block type, including 0x4B with a nonzero O code, SHALL give an error block plus rx_bad_block.
REQ-023 A two-state machine SHALL track framing:
- IDLE: data block -> error block, rx_sequence_error, stay IDLE; start (0x78/0x33) -> FRAME.
- FRAME: data -> stay FRAME; terminate -> IDLE.
- FRAME: start -> error block, rx_sequence_error, stay FRAME.
- FRAME: any other control or bad block -> error block, rx_sequence_error (plus rx_bad_block if undecodable), -> IDLE.
REQ-024 While rx_block_lock=0, outputs SHALL be local fault (rxd = 0x0100009C0100009C, rxc = 0x11), flags SHALL be 0, and the state SHALL be forced to IDLE.
REQ-025 rx_bad_block and rx_sequence_error SHALL be able to assert in the same cycle.

Reset
REQ-026 When rst=1 at a clock edge, outputs SHALL be rxd = 0x0707070707070707 and rxc = 0xFF, flags SHALL be 0, and the state SHALL be IDLE; this applies mid-frame too, and the next start is accepted without a sequence error.

Structure
REQ-027 A shared package SHALL hold the block-type constants, the XGMII character constants (/I/ /S/ /T/ /E/ /O/) and the 7-bit control-code constants.
REQ-028 One combinational sub-module baser_ctrl_code_dec SHALL map a 7-bit code to an XGMII byte plus an invalid flag; it is instantiated per lane.

Verification
REQ-029 Reset, then lock=1, then header 10 type 0x1E all-zero -> rxd 0x0707070707070707, rxc 0xFF, no flags.
REQ-030 Start 0x78 payload 0x..D5555555555555, then data 0x1122334455667788, then type 0xFF -> rxd 0xD5555555555555FB/rxc 0x01, then data/rxc 0x00, then lane 7 = 0xFD with rxc 0x80; no flags.
REQ-031 Header 11 mid-frame -> error block, rx_bad_block=1 and rx_sequence_error=1; a following data block -> error block plus sequence error.
REQ-032 Data block while IDLE -> 0xFEFE..FE / 0xFF plus rx_sequence_error; a start then decodes normally.
REQ-033 rx_block_lock dropped mid-frame -> 0x0100009C0100009C / 0x11; after relock, data before start -> sequence error.
REQ-034 Type 0x33 with bits 35:8 = 0 and data 0xD55555 -> rxd 0xD55555FB07070707, rxc 0x1F.
